// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream into little-endian 32-bit words,
// drives the memory write port and holds the CPU in reset until a frame checks out.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  wr_en,
  output logic [31:0]           wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned LW = 17;
  localparam logic [LW-1:0] MAX_LEN = LW'(2**ADDR_WIDTH);
  localparam logic [7:0]    SYNC    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [LW-1:0]   len_q, len_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     shift_q, shift_d;
  logic [7:0]      csum_q, csum_d;
  logic [CW-1:0]   word_count_q, word_count_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;

  logic            accept;
  logic [LW-1:0]   len_full;
  logic            word_last;
  logic            frame_last;

  assign accept     = in_valid && in_ready;
  assign len_full   = {1'b0, in_data, len_lo_q};
  assign word_last  = (byte_idx_q == 2'd3);
  // The word now completing is the last one of the frame.
  assign frame_last = ((LW'(word_count_q) + LW'(1)) == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SYNC)) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (accept) state_d = S_LEN1;
      end
      S_LEN1: begin
        if (accept) begin
          if (len_full > MAX_LEN)   state_d = S_ERR;
          else if (len_full == '0)  state_d = S_CSUM;
          else                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && word_last && frame_last) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (restart) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   error    = 1'b1;
      default: in_ready = !reset;
    endcase
  end

  // Datapath next-state: length, word assembly, checksum, write port
  always_comb begin
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    word_count_d = word_count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SYNC)) begin
          word_count_d = '0;
          csum_d       = '0;
          byte_idx_d   = '0;
        end
      end
      S_LEN0: begin
        if (accept) len_lo_d = in_data;
      end
      S_LEN1: begin
        if (accept) len_d = len_full;
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: shift_d[7:0]   = in_data;
            2'd1: shift_d[15:8]  = in_data;
            2'd2: shift_d[23:16] = in_data;
            default: begin
              wr_en_d      = 1'b1;
              wr_data_d    = {in_data, shift_q};
              wr_addr_d    = BASE_ADDR + (32'(word_count_q) << 2);
              word_count_d = word_count_q + CW'(1);
            end
          endcase
        end
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          csum_d     = '0;
          byte_idx_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo_q     <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      csum_q       <= '0;
      word_count_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      word_count_q <= word_count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level reference model driven by randomized frames,
// checked on every cycle, plus literal expectations for the directed frames.
module tb_imem_loader;

  localparam int unsigned AW   = 12;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk;
  logic        reset, in_valid, restart;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_addr, wr_data;
  logic [AW:0] word_count;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .word_count(word_count), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Frame-level model state
  logic [7:0]  fr[$];
  logic [63:0] wlog[$];
  int          m_len = 0;
  int          m_cnt = 0;
  bit          m_wr = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Effect of accepting frame byte p, derived from its position in the frame.
  task automatic model_byte(input int p);
    logic [7:0] cs;
    if (p == 0) begin
      m_cnt = 0;
    end else if (p == 2) begin
      m_len = int'({fr[2], fr[1]});
      if (m_len > (1 << AW)) m_err = 1'b1;
    end else if (p >= 3 && p < 3 + 4 * m_len) begin
      if ((p - 3) % 4 == 3) begin
        m_wr   = 1'b1;
        m_cnt  = (p - 3) / 4 + 1;
        m_addr = BASE + 32'((m_cnt - 1) * 4);
        m_data = {fr[p], fr[p-1], fr[p-2], fr[p-3]};
      end
    end else if (p == 3 + 4 * m_len) begin
      cs = 8'h00;
      for (int i = 3; i < p; i++) cs ^= fr[i];
      if (fr[p] == cs) m_done = 1'b1;
      else             m_err  = 1'b1;
    end
  endtask

  // One clock: drive inputs now, advance past the edge, update the model.
  task automatic tick(input bit v, input logic [7:0] d, input int pos, input bit rs, input bit rst);
    bit acc;
    in_valid = v;
    in_data  = d;
    restart  = rs;
    reset    = rst;
    acc = v && !rst && !m_done && !m_err;
    @(posedge clk);
    #1;
    m_wr = 1'b0;
    if (rst) begin
      m_done = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else if (rs && (m_done || m_err)) begin
      m_done = 1'b0;
      m_err  = 1'b0;
    end else if (acc && pos >= 0) begin
      model_byte(pos);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, -1, 1'b0, 1'b0);
  endtask

  task automatic garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h3C;
      tick(1'b1, g, -1, 1'($urandom_range(0, 3) == 0), 1'b0);
    end
  endtask

  task automatic make_frame(input int len, input bit bad);
    logic [7:0] b, cs;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(8'(len));
    fr.push_back(8'(len >> 8));
    cs = 8'h00;
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom_range(0, 255));
      cs ^= b;
      fr.push_back(b);
    end
    fr.push_back(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs);
  endtask

  task automatic make_t2(input logic [7:0] csum);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    fr[11] = csum;
  endtask

  // Send fr[0..stop_at] (all if stop_at<0) with random gaps and ignored restarts.
  task automatic send_frame(input int gap_pct, input int stop_at);
    for (int p = 0; p < fr.size(); p++) begin
      if (stop_at >= 0 && p > stop_at) break;
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 99) >= gap_pct) break;
        tick(1'b0, 8'($urandom_range(0, 255)), -1, 1'b0, 1'b0);
      end
      tick(1'b1, fr[p], p, 1'($urandom_range(0, 7) == 0), 1'b0);
      if (m_done || m_err) break;
    end
  endtask

  task automatic close_frame();
    garbage(2);
    tick(1'b1, 8'h55, -1, 1'b1, 1'b0);
    idle(1);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready",   32'(in_ready),   32'(!reset && !m_done && !m_err));
      chk("wr_en",      32'(wr_en),      32'(m_wr));
      chk("done",       32'(done),       32'(m_done));
      chk("error",      32'(error),      32'(m_err));
      chk("cpu_hold",   32'(cpu_hold),   32'(!m_done));
      chk("word_count", 32'(word_count), 32'(m_cnt));
      if (m_wr) begin
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
      end
      if (wr_en) wlog.push_back({wr_addr, wr_data});
    end
  end

  initial begin
    int base;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;

    // Reset held three cycles
    @(posedge clk); #1;
    check_en = 1'b1;
    tick(1'b0, 8'h00, -1, 1'b0, 1'b1);
    tick(1'b0, 8'h00, -1, 1'b0, 1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_wr_data",  wr_data, 32'h0);
    reset = 1'b0; #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    idle(1);

    // Directed good frame
    base = wlog.size();
    make_t2(8'h2A);
    send_frame(0, -1);
    chk("t2_done",  32'(done), 32'd1);
    chk("t2_hold",  32'(cpu_hold), 32'd0);
    chk("t2_count", 32'(word_count), 32'd2);
    chk("t2_nwr",   32'(wlog.size() - base), 32'd2);
    if (wlog.size() - base == 2) begin
      chk("t2_w0", wlog[base][31:0],  32'h12345678);
      chk("t2_a0", wlog[base][63:32], 32'h0);
      chk("t2_w1", wlog[base+1][31:0],  32'hDEADBEEF);
      chk("t2_a1", wlog[base+1][63:32], 32'h4);
    end
    close_frame();

    // Bad checksum
    base = wlog.size();
    make_t2(8'h2B);
    send_frame(0, -1);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_hold",  32'(cpu_hold), 32'd1);
    chk("t3_nwr",   32'(wlog.size() - base), 32'd2);
    tick(1'b0, 8'h00, -1, 1'b1, 1'b0);
    chk("t3_restart_err", 32'(error), 32'd0);
    chk("t3_restart_rdy", 32'(in_ready), 32'd1);

    // Garbage prefix and gaps
    base = wlog.size();
    tick(1'b1, 8'h00, -1, 1'b0, 1'b0);
    tick(1'b1, 8'hFF, -1, 1'b0, 1'b0);
    tick(1'b1, 8'h13, -1, 1'b0, 1'b0);
    make_t2(8'h2A);
    send_frame(40, -1);
    chk("t4_done", 32'(done), 32'd1);
    if (wlog.size() - base == 2) chk("t4_w1", wlog[base+1][31:0], 32'hDEADBEEF);
    else chk("t4_nwr", 32'(wlog.size() - base), 32'd2);
    close_frame();

    // Oversized length
    base = wlog.size();
    fr = '{8'hA5, 8'h01, 8'h10};
    send_frame(0, -1);
    chk("t5_error", 32'(error), 32'd1);
    garbage(4);
    chk("t5_nwr", 32'(wlog.size() - base), 32'd0);
    close_frame();

    // Reset after the 6th payload byte, then resend
    base = wlog.size();
    make_t2(8'h2A);
    send_frame(0, 8);
    tick(1'b0, 8'h00, -1, 1'b0, 1'b1);
    tick(1'b1, 8'h34, -1, 1'b0, 1'b1);
    chk("t6_nwr",  32'(wlog.size() - base), 32'd1);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    idle(2);
    send_frame(20, -1);
    chk("t6_done", 32'(done), 32'd1);
    close_frame();

    // Zero-length frames
    make_frame(0, 1'b0);
    send_frame(0, -1);
    chk("len0_done", 32'(done), 32'd1);
    close_frame();
    make_frame(0, 1'b1);
    send_frame(0, -1);
    chk("len0_err", 32'(error), 32'd1);
    close_frame();

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      garbage($urandom_range(0, 3));
      make_frame($urandom_range(0, 8), 1'($urandom_range(0, 3) == 0));
      send_frame(30, -1);
      close_frame();
    end

    // Largest legal frame
    base = wlog.size();
    make_frame(1 << AW, 1'b0);
    send_frame(0, -1);
    chk("max_done",  32'(done), 32'd1);
    chk("max_count", 32'(word_count), 32'(1 << AW));
    chk("max_last_addr", wlog[wlog.size()-1][63:32], 32'h0000_3FFC);
    close_frame();

    idle(3);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
